// File: rtl/matmul3x3_mac_engine.sv
// 3x3 signed matrix-multiply engine behind a decoded register bus; one shared MAC, 4 cycles per C element.
// Optional build macro MATMUL_SAT_EN: saturate stored results instead of wrapping.
module matmul3x3_mac_engine #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int GUARD  = 2
) (
  input  logic        system1000,
  input  logic        system1000_rst,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_wen,
  input  logic        bus_ren,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  output logic        bus_err,
  output logic        irq_done
);

  localparam int AW = 2*DATA_W + GUARD;

  typedef enum logic [1:0] {IDLE, MAC, STORE} state_t;

  state_t state_q, state_d;

  logic signed [DATA_W-1:0] a_mem [9];
  logic signed [DATA_W-1:0] b_mem [9];
  logic signed [ACC_W-1:0]  c_mem [9];
  logic signed [AW-1:0]     acc_q;
  logic [1:0] i_q, j_q, k_q;
  logic       done_q;
  logic       busy;
  logic       last_elem;

  assign busy      = (state_q != IDLE);
  assign last_elem = (i_q == 2'd2) && (j_q == 2'd2);

  // ---------------- bus decode ----------------
  logic [5:0]  off;
  logic [3:0]  b_idx, c_idx;
  logic        is_a, is_b, is_c, is_ctrl, is_stat;
  logic        req, bad, start_acc, wr_a, wr_b;
  logic [31:0] rd_val;
  logic        unused_bits;

  assign off   = bus_addr[7:2];
  assign b_idx = off[3:0] - 4'd9;   // modulo-16 offset into B (0x24..0x44)
  assign c_idx = off[3:0] - 4'd2;   // 18 mod 16 == 2 (0x48..0x68)
  assign unused_bits = ^{bus_addr[31:8], bus_addr[1:0], bus_wdata[31:DATA_W]};

  always_comb begin
    is_a    = (off < 6'd9);
    is_b    = (off >= 6'd9)  && (off < 6'd18);
    is_c    = (off >= 6'd18) && (off < 6'd27);
    is_ctrl = (off == 6'd28);
    is_stat = (off == 6'd29);
    req     = bus_wen | bus_ren;
    bad     = 1'b0;
    if (bus_wen && bus_ren)
      bad = 1'b1;
    else if (bus_wen) begin
      if (is_a || is_b)  bad = busy;
      else if (is_ctrl)  bad = busy && bus_wdata[0];
      else               bad = 1'b1;
    end else if (bus_ren)
      bad = !(is_a || is_b || is_c || is_ctrl || is_stat);
    start_acc = bus_wen && !bus_ren && is_ctrl && bus_wdata[0] && !busy;
    wr_a      = bus_wen && !bad && is_a;
    wr_b      = bus_wen && !bad && is_b;

    rd_val = '0;
    if (is_a)         rd_val = 32'(a_mem[off[3:0]]);
    else if (is_b)    rd_val = 32'(b_mem[b_idx]);
    else if (is_c)    rd_val = 32'(c_mem[c_idx]);
    else if (is_stat) rd_val = {30'd0, done_q, busy};
  end

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      bus_ack   <= 1'b0;
      bus_err   <= 1'b0;
      bus_rdata <= '0;
    end else begin
      bus_ack   <= req;
      bus_err   <= req && bad;
      bus_rdata <= (bus_ren && !bus_wen && !bad) ? rd_val : '0;
    end
  end

  // ---------------- MAC datapath ----------------
  logic [3:0]              a_sel, b_sel, c_sel;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [AW-1:0]    acc_sum;
  logic signed [ACC_W-1:0] store_val;

  always_comb begin
    a_sel   = 4'(i_q) * 4'd3 + 4'(k_q);
    b_sel   = 4'(k_q) * 4'd3 + 4'(j_q);
    c_sel   = 4'(i_q) * 4'd3 + 4'(j_q);
    prod    = (2*DATA_W)'(a_mem[a_sel]) * (2*DATA_W)'(b_mem[b_sel]);
    acc_sum = acc_q + {{GUARD{prod[2*DATA_W-1]}}, prod};
`ifdef MATMUL_SAT_EN
    // Upper bits all equal to the ACC_W sign bit means the value fits.
    if ((acc_q[AW-1:ACC_W-1] == '0) || (acc_q[AW-1:ACC_W-1] == '1))
      store_val = acc_q[ACC_W-1:0];
    else if (acc_q[AW-1])
      store_val = {1'b1, {(ACC_W-1){1'b0}}};
    else
      store_val = {1'b0, {(ACC_W-1){1'b1}}};
`else
    store_val = acc_q[ACC_W-1:0];
`endif
  end

  // ---------------- FSM ----------------
  always_ff @(posedge system1000) begin
    if (system1000_rst) state_q <= IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_acc) state_d = MAC;
      MAC:     if (k_q == 2'd2) state_d = STORE;
      STORE:   state_d = last_elem ? IDLE : MAC;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      for (int unsigned n = 0; n < 9; n++) begin
        a_mem[n] <= '0;
        b_mem[n] <= '0;
        c_mem[n] <= '0;
      end
      acc_q    <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      done_q   <= 1'b0;
      irq_done <= 1'b0;
    end else begin
      irq_done <= 1'b0;
      if (wr_a) a_mem[off[3:0]] <= bus_wdata[DATA_W-1:0];
      if (wr_b) b_mem[b_idx]    <= bus_wdata[DATA_W-1:0];
      if (start_acc) begin
        acc_q  <= '0;
        i_q    <= '0;
        j_q    <= '0;
        k_q    <= '0;
        done_q <= 1'b0;
      end
      case (state_q)
        MAC: begin
          acc_q <= acc_sum;
          k_q   <= (k_q == 2'd2) ? 2'd0 : k_q + 2'd1;
        end
        STORE: begin
          c_mem[c_sel] <= store_val;
          acc_q        <= '0;
          if (j_q == 2'd2) begin
            j_q <= '0;
            i_q <= last_elem ? 2'd0 : i_q + 2'd1;
          end else
            j_q <= j_q + 2'd1;
          if (last_elem) begin
            done_q   <= 1'b1;
            irq_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul3x3_mac_engine.sv
// Scoreboard bench for matmul3x3_mac_engine: bus driver queues expected replies, a monitor checks each ack.
module tb_matmul3x3_mac_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_wen, bus_ren, bus_ack, bus_err, irq_done;

  always #5 clk = ~clk;

  matmul3x3_mac_engine #(.DATA_W(16), .ACC_W(32), .GUARD(2)) dut (
    .system1000     (clk),
    .system1000_rst (rst),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_wen        (bus_wen),
    .bus_ren        (bus_ren),
    .bus_rdata      (bus_rdata),
    .bus_ack        (bus_ack),
    .bus_err        (bus_err),
    .irq_done       (irq_done)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          id;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  int          irq_count = 0;
  int          txn_id = 0;
  logic [15:0] ma[9], mb[9];
  logic [31:0] mc[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per ack
  always @(negedge clk) begin
    if (irq_done === 1'b1) irq_count++;
    if (bus_ack === 1'b1) begin
      if (sbq.size() == 0)
        chk("unexpected_ack", 32'd1, 32'd0);
      else begin
        mon_e = sbq.pop_front();
        chk($sformatf("rdata#%0d", mon_e.id), bus_rdata, mon_e.rdata);
        chk($sformatf("err#%0d", mon_e.id), {31'd0, bus_err}, {31'd0, mon_e.err});
      end
    end
  end

  task automatic bus(input logic w, input logic r, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.id    = txn_id++;
    sbq.push_back(e);
    @(negedge clk);
    bus_wen = w; bus_ren = r; bus_addr = addr; bus_wdata = wd;
    @(negedge clk);
    bus_wen = 1'b0; bus_ren = 1'b0;
  endtask

  function automatic logic [31:0] sext(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic void compute();
    longint s;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        s = 0;
        for (int k = 0; k < 3; k++)
          s += longint'($signed(ma[i*3+k])) * longint'($signed(mb[k*3+j]));
`ifdef MATMUL_SAT_EN
        if (s > 64'sd2147483647)        mc[i*3+j] = 32'h7FFF_FFFF;
        else if (s < -64'sd2147483648)  mc[i*3+j] = 32'h8000_0000;
        else                            mc[i*3+j] = s[31:0];
`else
        mc[i*3+j] = s[31:0];
`endif
      end
  endfunction

  task automatic load_mats();
    logic [31:0] r;
    for (int n = 0; n < 9; n++) begin
      r = $urandom();
      bus(1'b1, 1'b0, 32'(n*4), {r[31:16], ma[n]}, '0, 1'b0);
      r = $urandom();
      bus(1'b1, 1'b0, 32'(36 + n*4), {r[31:16], mb[n]}, '0, 1'b0);
    end
  endtask

  task automatic read_all_c();
    for (int n = 0; n < 9; n++) bus(1'b0, 1'b1, 32'(72 + n*4), '0, mc[n], 1'b0);
  endtask

  // Start, optionally probe the busy-time error paths, wait for irq, check latency and results
  task automatic run(input bit probe);
    time t0;
    int  irq0, cyc;
    bit  seen;
    irq0 = irq_count;
    bus(1'b1, 1'b0, 32'h70, 32'h1, '0, 1'b0);
    t0 = $time;
    compute();
    if (probe) begin
      bus(1'b1, 1'b0, 32'h00, 32'h1234, '0, 1'b1);
      bus(1'b1, 1'b0, 32'h70, 32'h1,    '0, 1'b1);
      bus(1'b0, 1'b1, 32'h7C, '0,       '0, 1'b1);
      bus(1'b1, 1'b1, 32'h00, 32'h55,   '0, 1'b1);
      bus(1'b0, 1'b1, 32'h74, '0,  32'h1, 1'b0);
      bus(1'b0, 1'b1, 32'h70, '0,  32'h0, 1'b0);
    end
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (irq_done === 1'b1) seen = 1'b1;
    end
    chk("irq_seen", {31'd0, seen}, 32'd1);
    cyc = int'(($time - t0) / 10);
    chk("busy_cycles", 32'(cyc), 32'd36);
    @(negedge clk);
    chk("irq_single_pulse", 32'(irq_count - irq0), 32'd1);
    bus(1'b0, 1'b1, 32'h74, '0, 32'h2, 1'b0);
    read_all_c();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int irq_before;
    rst = 1'b1; bus_wen = 1'b0; bus_ren = 1'b0; bus_addr = '0; bus_wdata = '0;
    for (int n = 0; n < 9; n++) begin ma[n] = '0; mb[n] = '0; mc[n] = '0; end
    repeat (3) @(negedge clk);
    chk("rst_rdata", bus_rdata, 32'd0);
    chk("rst_ack", {31'd0, bus_ack}, 32'd0);
    chk("rst_err", {31'd0, bus_err}, 32'd0);
    chk("rst_irq", {31'd0, irq_done}, 32'd0);
    rst = 1'b0;
    bus(1'b0, 1'b1, 32'h74, '0, 32'h0, 1'b0);
    bus(1'b0, 1'b1, 32'h48, '0, 32'h0, 1'b0);

    // idle-time error and misc decode cases
    bus(1'b0, 1'b1, 32'h6C, '0, '0, 1'b1);
    bus(1'b0, 1'b1, 32'h78, '0, '0, 1'b1);
    bus(1'b1, 1'b0, 32'h48, 32'h7, '0, 1'b1);
    bus(1'b1, 1'b0, 32'h74, 32'h7, '0, 1'b1);
    bus(1'b1, 1'b1, 32'h00, 32'h7, '0, 1'b1);
    bus(1'b1, 1'b0, 32'h70, 32'h0, '0, 1'b0);
    bus(1'b0, 1'b1, 32'h74, '0, 32'h0, 1'b0);

    // identity A, B = 1..9
    for (int n = 0; n < 9; n++) begin
      ma[n] = (n % 4 == 0) ? 16'd1 : 16'd0;
      mb[n] = 16'(n + 1);
    end
    load_mats();
    bus(1'b0, 1'b1, 32'hABCD_EF24, '0, 32'd1, 1'b0);
    run(1'b0);

    // -3 * 5
    for (int n = 0; n < 9; n++) begin ma[n] = '0; mb[n] = '0; end
    ma[0] = 16'hFFFD; mb[0] = 16'd5;
    load_mats();
    bus(1'b0, 1'b1, 32'h00, '0, 32'hFFFF_FFFD, 1'b0);
    run(1'b0);

    // extremes
    for (int n = 0; n < 9; n++) begin ma[n] = 16'h7FFF; mb[n] = 16'h7FFF; end
    load_mats();
    run(1'b0);
    for (int n = 0; n < 9; n++) begin ma[n] = 16'h8000; mb[n] = 16'h8000; end
    load_mats();
    run(1'b0);

    // random matrices; the first is also probed for busy-time errors
    for (int t = 0; t < 4; t++) begin
      for (int n = 0; n < 9; n++) begin
        ma[n] = 16'($urandom());
        mb[n] = 16'($urandom());
      end
      load_mats();
      run(t == 0);
      bus(1'b0, 1'b1, 32'h00, '0, sext(ma[0]), 1'b0);
      bus(1'b0, 1'b1, 32'h44, '0, sext(mb[8]), 1'b0);
    end

    // reset at cycle 10 of a computation
    irq_before = irq_count;
    bus(1'b1, 1'b0, 32'h70, 32'h1, '0, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 9; n++) begin ma[n] = '0; mb[n] = '0; mc[n] = '0; end
    repeat (50) @(negedge clk);
    chk("no_irq_after_abort", 32'(irq_count - irq_before), 32'd0);
    bus(1'b0, 1'b1, 32'h74, '0, 32'h0, 1'b0);
    bus(1'b0, 1'b1, 32'h00, '0, 32'h0, 1'b0);
    read_all_c();

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
